// File: rtl/io_out_sink.sv
// -----------------------------------------------------------------------------
// io_out_sink
//
// Receiving end of the CPU output port. Every cycle the CPU raises outFlag, the
// word on `out` is pushed into a DEPTH-word FIFO (no backpressure to the CPU).
// A small serializer pops words one at a time and sends them MSB byte first
// over a byte-wide valid/ready stream. startIO is raised the cycle after the
// host arms the sink and stays high until reset.
//
// Ports
//   clock        in   1        system clock, rising edge
//   reset        in   1        synchronous, active-low
//   arm          in   1        host request to start the CPU IO phase
//   startIO      out  1        IO phase enable toward the CPU (sticky)
//   outFlag      in   1        CPU output word valid this cycle
//   out          in   WIDTH    CPU output word
//   byteValid    out  1        stream byte valid
//   byteData     out  8        stream byte
//   byteReady    in   1        downstream accepts the byte
//   count        out  CW       words currently held in the FIFO (0..DEPTH)
//   overflow     out  1        sticky: a word was dropped on a full FIFO
//   o_dbg_state  out  2        serializer state (0 IDLE, 1 LOAD, 2 SEND)
//
// Stream handshake: a byte transfers on every rising edge where byteValid and
// byteReady are both 1. Once byteValid is raised it stays high, with byteData
// unchanged, until that transfer happens; byteReady may toggle freely.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module io_out_sink #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  output logic                     startIO,
  input  logic                     outFlag,
  input  logic [WIDTH-1:0]         out,
  output logic                     byteValid,
  output logic [7:0]               byteData,
  input  logic                     byteReady,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [1:0]               o_dbg_state
);

  localparam int NBYTES = WIDTH / 8;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              r_overflow;
  logic              r_start_io;

  logic [WIDTH-1:0]  r_shift;
  logic [IW-1:0]     r_idx;

  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_hs;
  logic              w_last;

  // The pop happens in LOAD, so a full FIFO can still take a word that cycle.
  assign w_pop  = (r_state == ST_LOAD);
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = outFlag && (!w_full || w_pop);
  assign w_drop = outFlag && w_full && !w_pop;

  assign w_hs   = (r_state == ST_SEND) && byteReady;
  assign w_last = (r_idx == IW'(NBYTES - 1));

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM. IDLE looks at the post-push count so a word pushed while
  // idle is loaded on the very next cycle; SEND does the same when finishing a
  // word so back-to-back words cost only one LOAD bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_count_nxt != '0) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (w_hs && w_last) begin
          w_state_nxt = (w_count_nxt != '0) ? ST_LOAD : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= out;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // The outgoing byte is always the top byte of the shift register; each
  // handshake shifts left by one byte, so after the last byte the register
  // is empty and byteData rests at zero until the next LOAD.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
      r_idx   <= '0;
    end else if (w_hs) begin
      r_shift <= r_shift << 8;
      r_idx   <= w_last ? '0 : r_idx + IW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_start_io <= 1'b0;
    end else if (arm) begin
      r_start_io <= 1'b1;
    end
  end

  assign startIO     = r_start_io;
  assign byteValid   = (r_state == ST_SEND);
  assign byteData    = r_shift[WIDTH-1 -: 8];
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_io_out_sink.sv
`timescale 1ns/1ps
module tb_io_out_sink;

  localparam int WIDTH  = 24;
  localparam int DEPTH  = 16;
  localparam int NBYTES = WIDTH / 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   arm = 1'b0;
  logic                   startIO;
  logic                   outFlag = 1'b0;
  logic [WIDTH-1:0]       out = '0;
  logic                   byteValid;
  logic [7:0]             byteData;
  logic                   byteReady = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [1:0]             dbg_state;

  always #5 clock = ~clock;

  io_out_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .arm         (arm),
    .startIO     (startIO),
    .outFlag     (outFlag),
    .out         (out),
    .byteValid   (byteValid),
    .byteData    (byteData),
    .byteReady   (byteReady),
    .count       (count),
    .overflow    (overflow),
    .o_dbg_state (dbg_state)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the FIFO is a queue of words, the word in flight is a
  // queue of remaining bytes, and m_load marks the one-cycle bubble in which
  // the head word moves from the FIFO into flight. Outputs are checked on the
  // falling edge, then the model advances with the inputs the DUT will sample
  // on the next rising edge.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] m_fifo [$];
  logic [7:0]       m_bytes [$];
  logic [7:0]       exp_q [$];
  bit               m_load, m_start, m_ovf, m_live;
  bit               m_pop, m_full, m_finish, m_idle;
  logic [WIDTH-1:0] m_head;

  always @(negedge clock) begin
    if (m_live) begin
      chk("model_count",    32'(count),    32'(m_fifo.size()));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
      chk("model_startIO",  32'(startIO),  32'(m_start));
      chk("model_valid",    32'(byteValid), 32'(m_bytes.size() > 0));
      if (m_bytes.size() > 0) chk("model_data", 32'(byteData), 32'(m_bytes[0]));
    end
    if (!reset) begin
      m_fifo.delete();
      m_bytes.delete();
      m_load  = 0;
      m_start = 0;
      m_ovf   = 0;
      m_live  = 1;
    end else begin
      m_pop    = m_load;
      m_full   = (m_fifo.size() == DEPTH);
      m_idle   = !m_load && (m_bytes.size() == 0);
      m_finish = 0;
      if (m_bytes.size() > 0 && byteReady) begin
        void'(m_bytes.pop_front());
        m_finish = (m_bytes.size() == 0);
      end
      if (m_pop) begin
        m_head = m_fifo.pop_front();
        for (int k = 0; k < NBYTES; k++) m_bytes.push_back(m_head[WIDTH-1-8*k -: 8]);
      end
      if (outFlag) begin
        if (m_full && !m_pop) m_ovf = 1;
        else                  m_fifo.push_back(out);
      end
      m_load = (m_idle || m_finish) && (m_fifo.size() > 0);
      if (arm) m_start = 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    outFlag = 1'b0;
    arm = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      @(negedge clock);
      if (count == 0 && !byteValid && dbg_state == 2'd0) begin
        done = 1;
        break;
      end
    end
    chk(name, 32'(done), 32'd1);
  endtask

  logic [WIDTH-1:0] words [18];

  initial begin
    // ---- 1: reset with outFlag asserted ----
    reset = 1'b0;
    outFlag = 1'b1;
    out = WIDTH'($urandom);
    tick();
    tick();
    reset = 1'b1;
    outFlag = 1'b0;
    @(negedge clock);
    chk("rst_count",    32'(count), 0);
    chk("rst_valid",    32'(byteValid), 0);
    chk("rst_data",     32'(byteData), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_startIO",  32'(startIO), 0);
    chk("rst_state",    32'(dbg_state), 0);
    tick();

    // ---- 2: single word, byteReady held 1 ----
    byteReady = 1'b1;
    out = 24'hA1B2C3;
    outFlag = 1'b1;
    @(negedge clock);
    chk("t2_count_pre", 32'(count), 0);
    tick();
    outFlag = 1'b0;
    @(negedge clock);
    chk("t2_count_t1", 32'(count), 1);
    chk("t2_load_t1",  32'(dbg_state), 1);
    chk("t2_valid_t1", 32'(byteValid), 0);
    tick();
    @(negedge clock);
    chk("t2_valid_t2", 32'(byteValid), 1);
    chk("t2_byte0",    32'(byteData), 32'h A1);
    tick();
    @(negedge clock);
    chk("t2_byte1", 32'(byteData), 32'h B2);
    tick();
    @(negedge clock);
    chk("t2_byte2", 32'(byteData), 32'h C3);
    tick();
    @(negedge clock);
    chk("t2_valid_end", 32'(byteValid), 0);
    chk("t2_count_end", 32'(count), 0);
    chk("t2_idle_end",  32'(dbg_state), 0);

    // ---- 3: stall mid-word ----
    out = 24'hA1B2C3;
    outFlag = 1'b1;
    tick();
    outFlag = 1'b0;
    tick();
    tick();
    byteReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t3_hold_valid", 32'(byteValid), 1);
      chk("t3_hold_data",  32'(byteData), 32'h B2);
      tick();
    end
    byteReady = 1'b1;
    @(negedge clock);
    chk("t3_b2_xfer", 32'(byteData), 32'h B2);
    tick();
    @(negedge clock);
    chk("t3_c3", 32'(byteData), 32'h C3);
    wait_idle("t3_drain", 20);

    // ---- 4: overflow; one word sits in the shift register, so 18 pushes
    //      fill FIFO plus shift register and drop exactly the last one ----
    do_reset();
    byteReady = 1'b0;
    for (int i = 0; i < 18; i++) begin
      words[i] = WIDTH'($urandom);
      out = words[i];
      outFlag = 1'b1;
      tick();
    end
    outFlag = 1'b0;
    @(negedge clock);
    chk("t4_count_full", 32'(count), 16);
    chk("t4_overflow",   32'(overflow), 1);
    chk("t4_first_byte", 32'(byteData), 32'(words[0][WIDTH-1 -: 8]));
    byteReady = 1'b1;
    wait_idle("t4_drain", 200);
    chk("t4_overflow_sticky", 32'(overflow), 1);

    // ---- 5: push on a full FIFO in the same cycle as the LOAD pop ----
    do_reset();
    byteReady = 1'b0;
    for (int i = 0; i < 17; i++) begin
      out = WIDTH'($urandom);
      outFlag = 1'b1;
      tick();
    end
    outFlag = 1'b0;
    byteReady = 1'b1;
    @(negedge clock);
    chk("t5_count_full", 32'(count), 16);
    chk("t5_no_ovf",     32'(overflow), 0);
    for (int i = 0; i < NBYTES; i++) tick();
    out = WIDTH'($urandom);
    outFlag = 1'b1;
    @(negedge clock);
    chk("t5_load", 32'(dbg_state), 1);
    tick();
    outFlag = 1'b0;
    @(negedge clock);
    chk("t5_count_kept", 32'(count), 16);
    chk("t5_ovf_kept",   32'(overflow), 0);
    wait_idle("t5_drain", 200);

    // ---- 6: arm timing and reset mid-SEND ----
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    arm = 1'b1;
    @(negedge clock);
    chk("t6_start_before", 32'(startIO), 0);
    tick();
    arm = 1'b0;
    @(negedge clock);
    chk("t6_start_after", 32'(startIO), 1);
    tick();
    tick();
    @(negedge clock);
    chk("t6_start_sticky", 32'(startIO), 1);
    byteReady = 1'b0;
    out = WIDTH'($urandom);
    outFlag = 1'b1;
    tick();
    outFlag = 1'b0;
    tick();
    @(negedge clock);
    chk("t6_in_send", 32'(byteValid), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clock);
    chk("t6_rst_valid", 32'(byteValid), 0);
    chk("t6_rst_start", 32'(startIO), 0);
    chk("t6_rst_count", 32'(count), 0);

    // ---- randomized traffic, including bursts that overflow ----
    for (int i = 0; i < 900; i++) begin
      int burst = (i % 300) < 60;
      outFlag   = burst ? 1'b1 : ($urandom_range(0, 99) < 35);
      out       = WIDTH'($urandom);
      byteReady = burst ? ($urandom_range(0, 99) < 10) : ($urandom_range(0, 99) < 70);
      arm       = ($urandom_range(0, 99) < 2);
      tick();
    end
    outFlag = 1'b0;
    arm = 1'b0;
    byteReady = 1'b1;
    wait_idle("rand_drain", 200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
